// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq: emits successive entries of a constant table, one per accepted control token.
// Define HANDSHAKE_CONSTANT_SEQ_SKID_EN to add a skid entry and register ctrl_ready.
module handshake_constant_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [DATA_WIDTH*DEPTH-1:0] TABLE = '0,
    parameter bit WRAP = 1'b1,
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  rewind,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_W-1:0]      outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    logic [IDX_W-1:0] idx, sel, nxt;
    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic fire;
    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        assign entries[k] = TABLE[k*DATA_WIDTH +: DATA_WIDTH];
    end
    assign fire = ctrl_valid && ctrl_ready;
    always_comb begin
        sel = rewind ? '0 : idx;
        nxt = sel == IDX_W'(DEPTH - 1) ? (WRAP ? '0 : sel) : sel + 1'b1;
    end
`ifdef HANDSHAKE_CONSTANT_SEQ_SKID_EN
    logic [DATA_WIDTH-1:0] skid;
    logic [IDX_W-1:0] skid_idx;
    logic skid_full;
    assign ctrl_ready = !skid_full;
    always_ff @(posedge clk) begin
        if (rst) begin
            outs       <= '0;
            outs_idx   <= '0;
            outs_valid <= 1'b0;
            idx        <= '0;
            skid       <= '0;
            skid_idx   <= '0;
            skid_full  <= 1'b0;
        end else begin
            if (fire)
                idx <= nxt;
            if (skid_full) begin
                if (outs_ready) begin
                    outs      <= skid;
                    outs_idx  <= skid_idx;
                    skid_full <= 1'b0;
                end
            end else if (fire && outs_valid && !outs_ready) begin
                skid      <= entries[sel];
                skid_idx  <= sel;
                skid_full <= 1'b1;
            end else if (fire) begin
                outs       <= entries[sel];
                outs_idx   <= sel;
                outs_valid <= 1'b1;
            end else if (outs_ready)
                outs_valid <= 1'b0;
        end
    end
`else
    assign ctrl_ready = !outs_valid || outs_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            outs       <= '0;
            outs_idx   <= '0;
            outs_valid <= 1'b0;
            idx        <= '0;
        end else if (fire) begin
            outs       <= entries[sel];
            outs_idx   <= sel;
            outs_valid <= 1'b1;
            idx        <= nxt;
        end else if (outs_ready)
            outs_valid <= 1'b0;
    end
`endif
endmodule
